// File: rtl/fft_input_loader.sv
// Purpose: packs a real sample stream into one FFT frame across RAM_A's four banks, then starts the core.
// Latency: one cycle from an accepted sample to its bank write on oDATA/oADDR_WR_x/oWE_x.
// Backpressure: oREADY is high only while loading; it stays low from the last sample until the core reports done.
module fft_input_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iVALID,
    input  logic [DATA_W-1:0] iDATA,
    output logic              oREADY,
    output logic [DATA_W-1:0] oDATA,
    output logic [ADDR_W-1:0] oADDR_WR_0,
    output logic [ADDR_W-1:0] oADDR_WR_1,
    output logic [ADDR_W-1:0] oADDR_WR_2,
    output logic [ADDR_W-1:0] oADDR_WR_3,
    output logic              oWE_0,
    output logic              oWE_1,
    output logic              oWE_2,
    output logic              oWE_3,
    output logic              oSTART,
    input  logic              iFFT_RDY,
    output logic              oBUSY,
    output logic [7:0]        oFRAME_CNT
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FLUSH = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W+1:0]   cnt_q;
    logic [DATA_W-1:0]   data_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          we_q;
    logic                start_q;
    logic                busy_q;
    logic [7:0]          frame_cnt_q;

    logic                accept_d;
    logic                last_d;
    logic [3:0]          we_sel_d;

    // Handshake and per-sample decode: bank comes from the low two index bits.
    always_comb begin
        oREADY   = (state_q == S_LOAD);
        accept_d = iVALID && (state_q == S_LOAD);
        last_d   = (cnt_q == '1);
        we_sel_d = 4'b0001 << cnt_q[1:0];
    end

    // Frame sequencer with registered bank-write, start and status outputs.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            data_q      <= '0;
            addr_q      <= '0;
            we_q        <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            // Write enables and the start strobe are single-cycle unless re-armed below.
            we_q    <= '0;
            start_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (accept_d) begin
                        data_q <= iDATA;
                        addr_q <= cnt_q[ADDR_W+1:2];
                        we_q   <= we_sel_d;
                        cnt_q  <= cnt_q + 1'b1;
                        busy_q <= 1'b1;
                        if (last_d) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Last bank write is on the bus now; the start pulse follows it.
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    // Core done is not honoured here; WAIT must see it on a later edge.
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (iFFT_RDY) begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        busy_q      <= 1'b0;
                        state_q     <= S_LOAD;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    // All banks share one address; only the enabled bank actually writes.
    assign oDATA      = data_q;
    assign oADDR_WR_0 = addr_q;
    assign oADDR_WR_1 = addr_q;
    assign oADDR_WR_2 = addr_q;
    assign oADDR_WR_3 = addr_q;
    assign oWE_0      = we_q[0];
    assign oWE_1      = we_q[1];
    assign oWE_2      = we_q[2];
    assign oWE_3      = we_q[3];
    assign oSTART     = start_q;
    assign oBUSY      = busy_q;
    assign oFRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader with a reduced frame (ADDR_W=4, N=64) so the
// 256-frame wrap run stays short; bank = n%4, address = n/4 at any frame size.
module tb_fft_input_loader;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int N  = 4 << AW;

    logic          clk;
    logic          rst;
    logic          vld;
    logic [DW-1:0] din;
    logic          rdy;
    logic [DW-1:0] dout;
    logic [AW-1:0] a0, a1, a2, a3;
    logic          we0, we1, we2, we3;
    logic          start;
    logic          fft_rdy;
    logic          busy;
    logic [7:0]    fcnt;

    int errs   = 0;
    int checks = 0;
    int fc_exp = 0;
    int we_pulses = 0;
    int start_pulses = 0;

    fft_input_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .iCLK(clk), .iRESET(rst), .iVALID(vld), .iDATA(din), .oREADY(rdy),
        .oDATA(dout), .oADDR_WR_0(a0), .oADDR_WR_1(a1), .oADDR_WR_2(a2), .oADDR_WR_3(a3),
        .oWE_0(we0), .oWE_1(we1), .oWE_2(we2), .oWE_3(we3), .oSTART(start),
        .iFFT_RDY(fft_rdy), .oBUSY(busy), .oFRAME_CNT(fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent tallies of write-enable and start activity seen at clock edges.
    always @(posedge clk) begin
        we_pulses    <= we_pulses + int'(we0) + int'(we1) + int'(we2) + int'(we3);
        start_pulses <= start_pulses + int'(start);
    end

    function automatic logic [3:0] we_vec();
        return {we3, we2, we1, we0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input int exp);
        chk("addr0", 32'(a0), 32'(exp));
        chk("addr1", 32'(a1), 32'(exp));
        chk("addr2", 32'(a2), 32'(exp));
        chk("addr3", 32'(a3), 32'(exp));
    endtask

    // Feed samples first..first+count-1; each accepted sample is checked one edge later.
    task automatic load_samples(input int first, input int count, input int base,
                                input bit toggle, input bit rdy_noise);
        logic [3:0] exp_we;
        for (int n = first; n < first + count; n++) begin
            if (toggle) begin
                vld = 1'b0;
                fft_rdy = rdy_noise;
                @(negedge clk);
                chk("gap_we", 32'(we_vec()), 32'd0);
            end
            chk("ready", 32'(rdy), 32'd1);
            vld = 1'b1;
            din = DW'(base + n);
            fft_rdy = rdy_noise && (n % 2 == 1);
            @(negedge clk);
            vld = 1'b0;
            fft_rdy = 1'b0;
            exp_we = 4'b0001 << (n % 4);
            chk("we_onehot", 32'(we_vec()), 32'(exp_we));
            chk_addr(n / 4);
            chk("data", 32'(dout), 32'(DW'(base + n)));
            chk("busy_load", 32'(busy), 32'd1);
            chk("fcnt_load", 32'(fcnt), 32'(fc_exp));
        end
    endtask

    // One full frame through FLUSH and START into WAIT.
    task automatic load_frame(input int base, input bit toggle, input bit rdy_noise);
        int p0;
        int s0;
        p0 = we_pulses;
        s0 = start_pulses;
        load_samples(0, N, base, toggle, rdy_noise);
        chk("flush_ready", 32'(rdy), 32'd0);
        chk("flush_start", 32'(start), 32'd0);
        vld = 1'b1;
        din = '1;
        fft_rdy = rdy_noise;
        @(negedge clk);
        chk("start_pulse", 32'(start), 32'd1);
        chk("start_we", 32'(we_vec()), 32'd0);
        chk("start_ready", 32'(rdy), 32'd0);
        chk("start_fcnt", 32'(fcnt), 32'(fc_exp));
        @(negedge clk);
        chk("wait_start_low", 32'(start), 32'd0);
        chk("wait_ready", 32'(rdy), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_fcnt", 32'(fcnt), 32'(fc_exp));
        fft_rdy = 1'b0;
        @(negedge clk);
        vld = 1'b0;
        chk("still_wait_ready", 32'(rdy), 32'd0);
        chk("still_wait_we", 32'(we_vec()), 32'd0);
        chk("frame_we_pulses", 32'(we_pulses - p0), 32'(N));
        chk("frame_start_pulses", 32'(start_pulses - s0), 32'd1);
    endtask

    task automatic finish_frame();
        vld = 1'b0;
        fft_rdy = 1'b1;
        @(negedge clk);
        fft_rdy = 1'b0;
        fc_exp = (fc_exp + 1) % 256;
        chk("done_fcnt", 32'(fcnt), 32'(fc_exp));
        chk("done_ready", 32'(rdy), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        vld = 1'b0;
        din = '0;
        fft_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'd1);
        chk("rst_we", 32'(we_vec()), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fcnt", 32'(fcnt), 32'd0);
        chk("rst_data", 32'(dout), 32'd0);
        chk_addr(0);
        rst = 1'b0;

        // Back-to-back stream, value = index, then a long hold in WAIT.
        load_frame(0, 1'b0, 1'b0);
        vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("hold_ready", 32'(rdy), 32'd0);
            chk("hold_we", 32'(we_vec()), 32'd0);
        end
        vld = 1'b0;
        finish_frame();

        // Done pulse while idle in LOAD must be ignored.
        fft_rdy = 1'b1;
        @(negedge clk);
        fft_rdy = 1'b0;
        chk("idle_rdy_fcnt", 32'(fcnt), 32'd1);
        chk("idle_rdy_ready", 32'(rdy), 32'd1);
        chk("idle_rdy_we", 32'(we_vec()), 32'd0);

        // Gapped stream with done pulses during LOAD, FLUSH and on the START edge.
        load_frame(1000, 1'b1, 1'b1);
        finish_frame();

        // Reset part-way through a frame discards it with no start pulse.
        s0 = start_pulses;
        load_samples(0, 21, 5000, 1'b0, 1'b0);
        rst = 1'b1;
        vld = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vld = 1'b0;
        fc_exp = 0;
        chk("mid_rst_we", 32'(we_vec()), 32'd0);
        chk("mid_rst_start", 32'(start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fcnt", 32'(fcnt), 32'd0);
        chk("mid_rst_ready", 32'(rdy), 32'd1);
        @(negedge clk);
        chk("mid_rst_no_start", 32'(start_pulses - s0), 32'd0);
        load_frame(7000, 1'b0, 1'b0);
        finish_frame();

        // 255 more frames: the 256th completion since reset wraps the counter.
        for (int f = 0; f < 255; f++) begin
            load_frame(f * 37, (f % 2 == 1), 1'b0);
            finish_frame();
            if (f == 253) chk("fcnt_255", 32'(fcnt), 32'd255);
        end
        chk("fcnt_wrap", 32'(fcnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
